operand_entry: RTL

Button-driven hexadecimal operand editor for the board front panel, generalising the two-operand 32-bit entry logic to NUM_OPS operands of WIDTH bits. The cursor moves over the digits of the displayed page, and the digit under the cursor increments or decrements on button presses. It runs fully synchronously on the board clock and uses edge detection on the debounced push-button levels. It feeds the ALU/display path with the operand vector and a per-digit blink mask.

---
 rtl/operand_entry_pkg.sv | 16 +
 rtl/operand_entry_btn_edge.sv | 23 ++
 rtl/operand_entry.sv | 110 +++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared constants and nibble arithmetic for the front-panel operand editor.
package operand_entry_pkg;

  localparam int DIGITS_PER_PAGE = 4;
  localparam int NIBBLE_W        = 4;

  // Wrapped single-digit step; never produces a carry or borrow.
  function automatic logic [NIBBLE_W-1:0] nib_add(input logic [NIBBLE_W-1:0] nibble,
                                                  input logic                up);
    logic [NIBBLE_W-1:0] res;
    if (up) res = nibble + 4'd1;
    else    res = nibble - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/operand_entry_btn_edge.sv
// Rising-edge detector for a bank of debounced button levels. The previous-value
// register resets to all ones so a button held through reset stays silent
// until it is released and pressed again.
module btn_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] level,
  output logic [N-1:0] pulse
);

  logic [N-1:0] prev;

  // Track last sampled level of each button.
  always_ff @(posedge clk) begin
    if (rst) prev <= '1;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/operand_entry.sv
// Button-driven hexadecimal editor for NUM_OPS operands of WIDTH bits. A 2-bit
// cursor walks the four digits of the selected 16-bit page; inc/dec step the
// digit under the cursor, and load overwrites the whole selected operand.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int                   WIDTH   = 32,
  parameter int                   NUM_OPS = 2,
  parameter int                   SEL_W   = 3,
  parameter int                   PAGE_W  = 1,
  parameter logic [NUM_OPS*WIDTH-1:0] INIT = {32'h12345678, 32'h87654321}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_move,
  input  logic                     btn_dir,
  input  logic                     btn_inc,
  input  logic                     btn_dec,
  input  logic [SEL_W-1:0]         sel,
  input  logic [PAGE_W-1:0]        page,
  input  logic                     load,
  input  logic [WIDTH-1:0]         load_data,
  output logic [NUM_OPS*WIDTH-1:0] operands,
  output logic [1:0]               cursor,
  output logic [3:0]               blink,
  output logic                     changed
);

  localparam int NUM_DIGITS = WIDTH / NIBBLE_W;

  logic [3:0]       btn_level;
  logic [3:0]       btn_pulse;
  logic             pulse_move;
  logic             pulse_inc;
  logic             pulse_dec;
  logic             edit_en;
  logic [PAGE_W+1:0] dig_idx;
  logic [WIDTH-1:0] ops     [NUM_OPS];
  logic [WIDTH-1:0] ops_nxt [NUM_OPS];
  logic             wr;
  logic [1:0]       cursor_r;

  assign btn_level = {btn_dec, btn_inc, btn_move, 1'b0};

  btn_edge #(.N(4)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_level),
    .pulse (btn_pulse)
  );

  assign pulse_move = btn_pulse[1];
  assign pulse_inc  = btn_pulse[2];
  assign pulse_dec  = btn_pulse[3];

  // Out-of-range sel values freeze the cursor and block every write.
  assign edit_en = (32'(sel) < NUM_OPS);

  // Digit under the cursor, counted from the least significant nibble.
  assign dig_idx = {page, cursor_r};

  // Next operand values: load wins, simultaneous inc+dec cancel, else step one nibble.
  always_comb begin
    wr = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) ops_nxt[k] = ops[k];
    for (int k = 0; k < NUM_OPS; k++) begin
      if (edit_en && (32'(sel) == k)) begin
        if (load) begin
          ops_nxt[k] = load_data;
          wr         = 1'b1;
        end else if (pulse_inc ^ pulse_dec) begin
          // Digits past the operand width never match, so no write happens there.
          for (int d = 0; d < NUM_DIGITS; d++) begin
            if (32'(dig_idx) == d) begin
              ops_nxt[k][d*NIBBLE_W +: NIBBLE_W] =
                nib_add(ops[k][d*NIBBLE_W +: NIBBLE_W], pulse_inc);
              wr = 1'b1;
            end
          end
        end
      end
    end
  end

  // Operand, cursor and change-pulse registers; writes use the pre-move cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPS; k++) ops[k] <= INIT[k*WIDTH +: WIDTH];
      cursor_r <= 2'd0;
      changed  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OPS; k++) ops[k] <= ops_nxt[k];
      changed <= wr;
      if (edit_en && pulse_move) begin
        if (btn_dir) cursor_r <= cursor_r + 2'd1;
        else         cursor_r <= cursor_r - 2'd1;
      end
    end
  end

  // Flatten the operand array onto the packed output bus.
  always_comb begin
    operands = '0;
    for (int k = 0; k < NUM_OPS; k++) operands[k*WIDTH +: WIDTH] = ops[k];
  end

  assign cursor = cursor_r;
  assign blink  = edit_en ? (4'b0001 << cursor_r) : 4'b0000;

endmodule
